// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial {c_out,sum} = a + b + c_in through a single full_adder
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic           carry_q;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;
  logic           fa_s;
  logic           fa_c;

  // cnt never exceeds WIDTH-1 while in RUN, so its low bits are a valid bit index
  assign idx = cnt[IW-1:0];

  full_adder u_fa (
    .a     (a_q[idx]),
    .b     (b_q[idx]),
    .c_in  (carry_q),
    .s     (fa_s),
    .c_out (fa_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      cnt     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            cnt     <= '0;
            sum     <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          sum[idx] <= fa_s;
          carry_q  <= fa_c;
          cnt      <= cnt + CW'(1);
          if (cnt == LAST) begin
            c_out <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q here is the carry into the MSB, fa_c the carry out of it
            ovf   <= carry_q ^ fa_c;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to add a, b, c_in; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on accepted start.
REQ-006 b  input  WIDTH  operand B; captured on accepted start.
REQ-007 c_in  input  1  initial carry; captured on accepted start.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse; sum and c_out valid.
REQ-010 sum  output  WIDTH  result; held until the next accepted start.
REQ-011 c_out  output  1  final carry; held with sum.

Function
REQ-012 Block SHALL compute {c_out,sum} = a + b + c_in bit-serially, LSB first, through one instance of the team's existing full_adder (ports a, b, c_in, s, c_out); no parallel adder.
REQ-013 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge -> latch a, b, c_in into internal shift/carry registers, clear bit counter, clear sum, go to RUN; start=0 -> stay in IDLE.
REQ-015 RUN: each edge feeds operand bit[cnt] and the carry register to full_adder, writes s into sum bit[cnt], loads c_out into the carry register, and increments cnt.
REQ-016 RUN SHALL last exactly WIDTH cycles; the edge that processes bit WIDTH-1 moves to DONE and loads the output c_out.
REQ-017 DONE: done=1 for exactly one cycle, busy=0, then unconditional return to IDLE.
REQ-018 Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH; next start is accepted no earlier than edge k+WIDTH+2.
REQ-019 start while in RUN or DONE SHALL be ignored (no queuing, no restart); a and b changes after capture SHALL have no effect.
REQ-020 sum and c_out SHALL only change on accept (sum cleared) and during RUN/DONE; they are stable in IDLE.
REQ-021 Wrap: all-ones + all-ones + c_in=1 SHALL give sum=all-ones, c_out=1; carry ripple across all WIDTH bits SHALL be exact.
REQ-022 Counter width SHALL be ceil(log2(WIDTH))+1 bits; no wrap during RUN.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, c_out=0, cnt=0, carry register=0, overriding start.
REQ-024 rst mid-RUN SHALL abort the operation with no done pulse; first start after rst deasserts is accepted normally.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN defined: extra output port ovf (1 bit), signed two's-complement overflow = carry into MSB XOR carry out of MSB; valid with done, held with sum, reset to 0.
REQ-026 Macro undefined: no ovf port or logic; all other behaviour identical.

Verification (WIDTH=8)
REQ-027 rst high 2 cycles, then low -> busy=0, done=0, sum=0x00, c_out=0.
REQ-028 a=0x35, b=0x4A, c_in=0, start 1 cycle -> busy 8 cycles, then done pulse with sum=0x7F, c_out=0.
REQ-029 a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1; a=0xFF, b=0x00, c_in=1 -> sum=0x00, c_out=1.
REQ-030 start held high continuously, a/b toggled during RUN -> exactly one done per WIDTH+2 cycles; results use the operands captured at accept.
REQ-031 rst asserted at RUN cycle 4 of a=0x12, b=0x34 -> no done pulse, outputs 0; following a=0x12, b=0x34 -> sum=0x46.
REQ-032 With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01, c_in=0 -> sum=0x80, ovf=1; a=0x80, b=0xFF -> sum=0x7F, c_out=1, ovf=1.
